// File: rtl/bram_bank_power_sequencer.sv
// Per-bank BRAM SLEEP sequencer: staggered wake grants, wake-latency tracking
// and a hold timer that keeps banks awake across short request dips.
module bram_bank_power_sequencer #(
  parameter int unsigned NUM_BANKS      = 8,
  parameter int unsigned WAKE_CYCLES    = 4,
  parameter int unsigned STAGGER_CYCLES = 2,
  parameter int unsigned SLEEP_DELAY    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_BANKS-1:0] bank_power_en,
  output logic [NUM_BANKS-1:0] bank_sleep,
  output logic [NUM_BANKS-1:0] bank_ready,
  output logic                 all_ready,
  output logic                 seq_busy
);

  localparam int unsigned MAX_CYCLES = (WAKE_CYCLES > SLEEP_DELAY) ? WAKE_CYCLES : SLEEP_DELAY;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int unsigned STG_W      = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_SLEEP  = 2'd0,
    ST_WAKING = 2'd1,
    ST_AWAKE  = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t               r_state     [NUM_BANKS];
  state_t               w_state_nxt [NUM_BANKS];
  logic [CNT_W-1:0]     r_cnt       [NUM_BANKS];
  logic [CNT_W-1:0]     w_cnt_nxt   [NUM_BANKS];
  logic [STG_W-1:0]     r_stagger;
  logic [STG_W-1:0]     w_stagger_nxt;
  logic [NUM_BANKS-1:0] r_sleep;
  logic [NUM_BANKS-1:0] r_ready;
  logic [NUM_BANKS-1:0] w_sleep_nxt;
  logic [NUM_BANKS-1:0] w_ready_nxt;
  logic [NUM_BANKS-1:0] w_sleep_mask;
  logic [NUM_BANKS-1:0] w_waking_mask;
  logic [NUM_BANKS-1:0] w_grant;
  logic                 w_found;

  // Fixed-priority wake arbiter gated by the shared stagger timer.
  always_comb begin
    w_grant       = '0;
    w_found       = 1'b0;
    w_sleep_mask  = '0;
    w_waking_mask = '0;
    w_stagger_nxt = r_stagger;
    for (int i = 0; i < NUM_BANKS; i++) begin
      w_sleep_mask[i]  = (r_state[i] == ST_SLEEP);
      w_waking_mask[i] = (r_state[i] == ST_WAKING);
    end
    if (r_stagger == '0) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (!w_found && bank_power_en[i] && w_sleep_mask[i]) begin
          w_grant[i] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
    if (w_found) begin
      w_stagger_nxt = STG_W'(STAGGER_CYCLES - 1);
    end else if (r_stagger != '0) begin
      w_stagger_nxt = r_stagger - STG_W'(1);
    end
  end

  // Per-bank next state; a counter value of 1 means it expires on this edge.
  always_comb begin
    w_sleep_nxt = '0;
    w_ready_nxt = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        ST_SLEEP: begin
          if (w_grant[i]) begin
            w_state_nxt[i] = ST_WAKING;
            w_cnt_nxt[i]   = CNT_W'(WAKE_CYCLES);
          end
        end
        ST_WAKING: begin
          if (r_cnt[i] <= CNT_W'(1)) begin
            if (bank_power_en[i]) begin
              w_state_nxt[i] = ST_AWAKE;
              w_cnt_nxt[i]   = '0;
            end else begin
              w_state_nxt[i] = ST_HOLD;
              w_cnt_nxt[i]   = CNT_W'(SLEEP_DELAY);
            end
          end else begin
            w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
          end
        end
        ST_AWAKE: begin
          if (!bank_power_en[i]) begin
            w_state_nxt[i] = ST_HOLD;
            w_cnt_nxt[i]   = CNT_W'(SLEEP_DELAY);
          end
        end
        ST_HOLD: begin
          if (bank_power_en[i]) begin
            w_state_nxt[i] = ST_AWAKE;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] <= CNT_W'(1)) begin
            w_state_nxt[i] = ST_SLEEP;
            w_cnt_nxt[i]   = '0;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt[i] = ST_SLEEP;
          w_cnt_nxt[i]   = '0;
        end
      endcase
      w_sleep_nxt[i] = (w_state_nxt[i] == ST_SLEEP);
      w_ready_nxt[i] = (w_state_nxt[i] == ST_AWAKE) || (w_state_nxt[i] == ST_HOLD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        r_state[i] <= ST_SLEEP;
        r_cnt[i]   <= '0;
      end
      r_stagger <= '0;
      r_sleep   <= '1;
      r_ready   <= '0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      r_stagger <= w_stagger_nxt;
      r_sleep   <= w_sleep_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  assign bank_sleep = r_sleep;
  assign bank_ready = r_ready;
  assign all_ready  = &(r_ready | ~bank_power_en);
  assign seq_busy   = (|w_waking_mask) | (|(bank_power_en & w_sleep_mask));

endmodule

// File: tb/tb_bram_bank_power_sequencer.sv
// Scoreboard bench for bram_bank_power_sequencer: an edge-count reference model
// predicts outputs per cycle, a monitor pops and compares after each edge.
module tb_bram_bank_power_sequencer;

  localparam int NB = 8;
  localparam int WK = 4;
  localparam int ST = 2;
  localparam int SD = 16;

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] bank_power_en;
  logic [NB-1:0] bank_sleep;
  logic [NB-1:0] bank_ready;
  logic          all_ready;
  logic          seq_busy;

  bram_bank_power_sequencer #(
    .NUM_BANKS     (NB),
    .WAKE_CYCLES   (WK),
    .STAGGER_CYCLES(ST),
    .SLEEP_DELAY   (SD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bank_power_en(bank_power_en),
    .bank_sleep   (bank_sleep),
    .bank_ready   (bank_ready),
    .all_ready    (all_ready),
    .seq_busy     (seq_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] sleep;
    logic [NB-1:0] ready;
    logic          all_r;
    logic          busy;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Model: a bank is either asleep or awake since grant edge g; it is usable
  // from edge g+WK on, and sleeps once SD+1 consecutive usable-phase edges
  // have sampled its request low.
  bit asleep   [NB];
  int gnt_edge [NB];
  int low_run  [NB];
  int edge_n;
  int last_grant;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      asleep[i]   = 1'b1;
      gnt_edge[i] = 0;
      low_run[i]  = 0;
    end
    edge_n     = 0;
    last_grant = -1000;
  endtask

  task automatic model_step(input logic [NB-1:0] req);
    int   g;
    exp_t e;
    edge_n++;
    g = -1;
    if (edge_n - last_grant >= ST) begin
      for (int i = 0; i < NB; i++) begin
        if (g < 0 && asleep[i] && req[i]) g = i;
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (!asleep[i] && edge_n >= gnt_edge[i] + WK) begin
        if (req[i]) low_run[i] = 0;
        else        low_run[i]++;
        if (low_run[i] > SD) begin
          asleep[i]  = 1'b1;
          low_run[i] = 0;
        end
      end
    end
    if (g >= 0) begin
      asleep[g]   = 1'b0;
      gnt_edge[g] = edge_n;
      low_run[g]  = 0;
      last_grant  = edge_n;
    end
    e.busy = 1'b0;
    for (int i = 0; i < NB; i++) begin
      e.sleep[i] = asleep[i];
      e.ready[i] = !asleep[i] && (edge_n >= gnt_edge[i] + WK);
      if (!asleep[i] && edge_n < gnt_edge[i] + WK) e.busy = 1'b1;
      if (asleep[i] && req[i]) e.busy = 1'b1;
    end
    e.all_r = &(e.ready | ~req);
    sb_q.push_back(e);
  endtask

  // Each call starts and ends on a falling edge; one model step per rising edge.
  task automatic drive(input logic [NB-1:0] pat, input int n);
    for (int k = 0; k < n; k++) begin
      bank_power_en = pat;
      model_step(pat);
      @(negedge clk);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("bank_sleep", 32'(bank_sleep), 32'(e.sleep));
      chk("bank_ready", 32'(bank_ready), 32'(e.ready));
      chk("all_ready",  32'(all_ready),  32'(e.all_r));
      chk("seq_busy",   32'(seq_busy),   32'(e.busy));
    end
  end

  initial begin
    logic [NB-1:0] pat;
    int            len;
    rst_n         = 1'b0;
    bank_power_en = '0;
    model_reset();
    #12;
    chk("rst_sleep",     32'(bank_sleep), 32'hFF);
    chk("rst_ready",     32'(bank_ready), 32'h00);
    chk("rst_all_ready", 32'(all_ready),  32'h1);
    chk("rst_busy",      32'(seq_busy),   32'h0);
    bank_power_en = 8'h01;
    #1;
    chk("rst_req_all_ready", 32'(all_ready), 32'h0);
    chk("rst_req_busy",      32'(seq_busy),  32'h1);
    bank_power_en = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    drive(8'h00, 2);
    drive(8'h08, 10);
    drive(8'h00, 22);
    drive(8'h0F, 14);
    drive(8'h00, 24);
    drive(8'h01, 8);
    drive(8'h00, 10);
    drive(8'h01, 4);
    drive(8'h00, 20);
    drive(8'h04, 1);
    drive(8'h00, 24);
    drive(8'hFF, 20);
    drive(8'hFF, 1);
    drive(8'h00, 20);

    for (int p = 0; p < 120; p++) begin
      pat = NB'($urandom);
      len = int'($urandom_range(1, 40));
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 7) == 0) pat[$urandom_range(0, NB - 1)] ^= 1'b1;
        drive(pat, 1);
      end
    end

    drive(8'h00, 22);
    drive(8'h0F, 9);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_sleep",     32'(bank_sleep), 32'hFF);
    chk("midrst_ready",     32'(bank_ready), 32'h00);
    chk("midrst_all_ready", 32'(all_ready),  32'h0);
    chk("midrst_busy",      32'(seq_busy),   32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive(8'h0F, 14);
    drive(8'h00, 22);

    @(posedge clk);
    #3;
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
